// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared sizing constants and helpers for the dual-port-RAM FIFO controller.
package fifo_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned OBUF_DEPTH     = 2;
  localparam int unsigned OBUF_CNT_W     = 2;

  // RAM words + one in-flight read + output buffer entries
  function automatic int unsigned occ_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_out_skid_buf.sv
// Two-entry in-order register FIFO that absorbs the RAM's registered read latency.
module out_skid_buf
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [OBUF_CNT_W-1:0] count
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [OBUF_CNT_W-1:0] cnt_q, cnt_d;
  logic [OBUF_CNT_W-1:0] cnt_pop;
  logic                  do_pop;

  // Pop shifts entry 1 forward; a write lands in the first free slot after the pop
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    do_pop  = rd_en && (cnt_q != '0);
    cnt_pop = cnt_q - OBUF_CNT_W'(do_pop);
    if (do_pop) begin
      ent0_d = ent1_q;
    end
    if (wr_en) begin
      if (cnt_pop == '0) begin
        ent0_d = wr_data;
      end else begin
        ent1_d = wr_data;
      end
    end
    cnt_d = cnt_pop + OBUF_CNT_W'(wr_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_data = ent0_q;
  assign count   = cnt_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO controller sequencing an external dual-port RAM (A = write, B = read)
// with a 2-entry output buffer hiding the RAM read latency.
module dpram_fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [occ_width(ADDR_WIDTH)-1:0] occupancy,
  output logic                             err_collision,
  output logic                             ram_we_a,
  output logic [ADDR_WIDTH-1:0]            ram_addr_a,
  output logic [DATA_WIDTH-1:0]            ram_din_a,
  output logic                             ram_we_b,
  output logic [ADDR_WIDTH-1:0]            ram_addr_b,
  output logic [DATA_WIDTH-1:0]            ram_din_b,
  input  logic [DATA_WIDTH-1:0]            ram_dout_b,
  input  logic                             ram_collision
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned OCC_W = occ_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic [OBUF_CNT_W-1:0] buf_cnt;
  logic [DATA_WIDTH-1:0] buf_head;
  logic                  push, pop, issue, full, room;

  // Handshakes and read issue; a read is issued only when the buffer can take its data
  always_comb begin
    full    = (ram_cnt_q == CNT_W'(DEPTH));
    s_ready = rst_n & ~full & ~flush;
    push    = s_valid & s_ready;
    m_valid = (buf_cnt != '0);
    pop     = m_valid & m_ready;
    room    = (3'(buf_cnt) + 3'(inflight_q)) < (3'(OBUF_DEPTH) + 3'(pop));
    issue   = rst_n & (ram_cnt_q != '0) & room & ~flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(issue);
    ram_cnt_d  = ram_cnt_q + CNT_W'(push) - CNT_W'(issue);
    inflight_d = issue;
    err_d      = err_q | ram_collision;
  end

  // Flush clears the datapath but keeps the sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      err_q      <= err_d;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  out_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (inflight_q),
    .wr_data (ram_dout_b),
    .rd_en   (pop),
    .rd_data (buf_head),
    .count   (buf_cnt)
  );

  assign m_data        = buf_head;
  assign occupancy     = OCC_W'(ram_cnt_q) + OCC_W'(inflight_q) + OCC_W'(buf_cnt);
  assign err_collision = err_q;
  assign ram_we_a      = push;
  assign ram_addr_a    = wr_ptr_q;
  assign ram_din_a     = s_data;
  assign ram_we_b      = 1'b0;
  assign ram_addr_b    = rd_ptr_q;
  assign ram_din_b     = '0;

endmodule
